// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - load/store sequencer splitting word-crossing accesses for a sync-read BRAM
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   req_valid/req_ready          core request handshake; ready only while IDLE
//   req_we, req_funct3           store flag and access size/extension code
//   req_addr, req_wdata          byte address (any alignment), right-justified store data
//   resp_valid                   one-cycle completion pulse
//   resp_rdata, resp_err         extended load data, access fault flag
//   mem_addr, mem_we, mem_wd     word-aligned address, lane-positioned enables and data
//   mem_rd                       memory read data, one cycle after mem_addr
//
// Optional feature macro: MISALIGN_TRAP_EN (word-crossing accesses fault instead of splitting).

module lsu_split #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, WAIT, DONE} state_t;

    state_t state, state_n;

    // Request fields latched at accept.
    logic        r_we;
    logic [1:0]  r_off;
    logic [1:0]  r_size;   // 0 byte, 1 half, 2 word
    logic        r_uns;
    logic        r_split;
    logic [3:0]  hi_we;    // second-word enables/data, computed once at accept
    logic [31:0] hi_wd;
    logic [31:0] word0;

    // Decode of the incoming request.
    logic [1:0]  size_a;
    logic        uns_a;
    logic [2:0]  nbytes_a;
    logic [3:0]  mask_a;
    logic [1:0]  off_a;
    logic        split_a;
    logic        trap_a;
    logic [7:0]  we8_a;
    logic [63:0] wd64_a;

    always_comb begin
        size_a = 2'd2;
        uns_a  = 1'b0;
        // Anything not a legal code for this direction falls back to a word access.
        case (req_funct3)
            3'b000: size_a = 2'd0;
            3'b001: size_a = 2'd1;
            3'b100: if (!req_we) begin size_a = 2'd0; uns_a = 1'b1; end
            3'b101: if (!req_we) begin size_a = 2'd1; uns_a = 1'b1; end
            default: ;
        endcase
        case (size_a)
            2'd0:    begin nbytes_a = 3'd1; mask_a = 4'b0001; end
            2'd1:    begin nbytes_a = 3'd2; mask_a = 4'b0011; end
            default: begin nbytes_a = 3'd4; mask_a = 4'b1111; end
        endcase
        off_a   = req_addr[1:0];
        split_a = (({1'b0, off_a} + nbytes_a) > 3'd4);
        we8_a   = {4'b0000, mask_a} << off_a;
        wd64_a  = {32'h0, req_wdata} << {off_a, 3'b000};
`ifdef MISALIGN_TRAP_EN
        trap_a  = split_a;
`else
        trap_a  = 1'b0;
`endif
    end

    // Load assembly: for a split load the low word was captured in ACC1 and the
    // high word is on mem_rd now; select the 32-bit window starting at the offset.
    logic [63:0] rd64;
    logic [31:0] rd_win;
    logic [31:0] ld_ext;

    always_comb begin
        rd64   = r_split ? {mem_rd, word0} : {32'h0, mem_rd};
        rd_win = rd64[{r_off, 3'b000} +: 32];
        case (r_size)
            2'd0:    ld_ext = {{24{~r_uns & rd_win[7]}}, rd_win[7:0]};
            2'd1:    ld_ext = {{16{~r_uns & rd_win[15]}}, rd_win[15:0]};
            default: ld_ext = rd_win;
        endcase
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req_valid) state_n = trap_a ? DONE : ACC0;
            ACC0: begin
                if (r_split)   state_n = ACC1;
                else if (r_we) state_n = DONE;
                else           state_n = WAIT;
            end
            ACC1: state_n = r_we ? DONE : WAIT;
            WAIT: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs are loaded on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= '0;
            mem_we     <= 4'b0000;
            mem_wd     <= 32'h0;
            r_we       <= 1'b0;
            r_off      <= 2'd0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
            r_split    <= 1'b0;
            hi_we      <= 4'b0000;
            hi_wd      <= 32'h0;
            word0      <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we <= 4'b0000;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_off   <= off_a;
                        r_size  <= size_a;
                        r_uns   <= uns_a;
                        r_split <= split_a;
                        hi_we   <= we8_a[7:4];
                        hi_wd   <= wd64_a[63:32];
                        if (trap_a) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_we) begin
                                mem_we <= we8_a[3:0];
                                mem_wd <= wd64_a[31:0];
                            end
                        end
                    end
                end
                ACC0: begin
                    if (r_split) begin
                        mem_addr <= mem_addr + ADDR_W'(4);
                        mem_we   <= r_we ? hi_we : 4'b0000;
                        if (r_we) mem_wd <= hi_wd;
                    end else begin
                        mem_we <= 4'b0000;
                        if (r_we) resp_valid <= 1'b1;
                    end
                end
                ACC1: begin
                    mem_we <= 4'b0000;
                    word0  <= mem_rd;
                    if (r_we) resp_valid <= 1'b1;
                end
                WAIT: begin
                    resp_rdata <= ld_ext;
                    resp_valid <= 1'b1;
                end
                default: mem_we <= 4'b0000;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) resp_err <= 1'b0;
        else     resp_err <= (state == IDLE) && req_valid && trap_a;
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule
